// File: rtl/jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : jump_redirect_ctrl
// Brief   : Resolves j/jal/jr/jalr targets in ID, holds the fetch redirect
//           until the delay slot is fetched, and emits the link write.
// Revision: 1.0 - initial release
// ============================================================================
module jump_redirect_ctrl #(
  parameter int         PC_W     = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic            id_jump_i,
  input  logic            id_jump_to_rs_val_i,
  input  logic            id_jsave_i,
  input  logic            id_save_in_rd_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic [25:0]     id_instr_index_i,
  input  logic [4:0]      id_rd_i,
  input  logic [PC_W-1:0] rs_value_i,
  input  logic            rs_ready_i,
  input  logic            if_ds_valid_i,
  input  logic            if_ready_i,
  output logic            id_stall_o,
  output logic            redirect_valid_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            link_we_o,
  output logic [4:0]      link_waddr_o,
  output logic [PC_W-1:0] link_wdata_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_RS = 2'd1,
    S_WAIT_DS = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            link_we_q, link_we_d;
  logic [4:0]      link_waddr_q, link_waddr_d;
  logic [PC_W-1:0] link_wdata_q, link_wdata_d;

  logic            w_jump;
  logic            w_accept;
  logic [PC_W-1:0] w_pc4;
  logic [PC_W-1:0] w_abs_target;
  logic            w_stall;

  assign w_jump       = id_valid_i & id_jump_i;
  assign w_accept     = ((state_q == S_IDLE) || (state_q == S_WAIT_RS)) & w_jump &
                        (~id_jump_to_rs_val_i | rs_ready_i) & ~flush_i;
  assign w_pc4        = id_pc_i + PC_W'(4);
  assign w_abs_target = {w_pc4[PC_W-1:28], id_instr_index_i, 2'b00};

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    link_we_d    = 1'b0;
    link_waddr_d = link_waddr_q;
    link_wdata_d = link_wdata_q;
    w_stall      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        w_stall = w_jump & id_jump_to_rs_val_i & ~rs_ready_i;
        if (w_accept)    state_d = S_WAIT_DS;
        else if (w_jump) state_d = S_WAIT_RS;
      end
      S_WAIT_RS: begin
        w_stall = w_jump & ~w_accept;
        // ID dropped the jump (e.g. squashed upstream): nothing left to wait for
        if (w_accept)     state_d = S_WAIT_DS;
        else if (!w_jump) state_d = S_IDLE;
      end
      S_WAIT_DS: begin
        // A second jump here sits in the delay slot; hold it until IDLE
        w_stall = w_jump;
        if (if_ds_valid_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        w_stall = w_jump;
        if (if_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_accept) begin
      target_d  = id_jump_to_rs_val_i ? rs_value_i : w_abs_target;
      link_we_d = id_jsave_i;
      if (id_jsave_i) begin
        link_waddr_d = id_save_in_rd_i ? id_rd_i : LINK_REG;
        link_wdata_d = id_pc_i + PC_W'(8);
      end
    end

    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      link_we_q    <= 1'b0;
      link_waddr_q <= '0;
      link_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      link_we_q    <= link_we_d;
      link_waddr_q <= link_waddr_d;
      link_wdata_q <= link_wdata_d;
    end
  end

  // Flush and reset must silence the combinational outputs in the same cycle
  assign id_stall_o       = w_stall & ~flush_i & ~rst;
  assign redirect_valid_o = (state_q == S_ISSUE) & ~flush_i & ~rst;
  assign redirect_pc_o    = target_q;
  assign link_we_o        = link_we_q;
  assign link_waddr_o     = link_waddr_q;
  assign link_wdata_o     = link_wdata_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule
`default_nettype wire
